mig_calib_monitor: RTL and testbench



---
 rtl/mig_calib_monitor.sv | 173 +++++++++++++++++
 tb/tb_mig_calib_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mig_calib_monitor.sv
// Calibration gate between the MIG reset generator and the system: releases sys_resetn
// once init_calib_complete is stable, retrying or failing on timeout (MIG_CALIB_RETRY_EN).
module mig_calib_monitor #(
    parameter int CAL_TIMEOUT  = 20000000,
    parameter int RELEASE_HOLD = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int RETRY_PULSE  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               mig_resetn,
    input  logic                               init_calib_complete,
    output logic                               mig_reset_req,
    output logic                               sys_resetn,
    output logic                               calib_done,
    output logic                               calib_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int TW  = $clog2(CAL_TIMEOUT);
    localparam int HW  = (RELEASE_HOLD > 1) ? $clog2(RELEASE_HOLD) : 1;
    localparam int PW  = (RETRY_PULSE > 1) ? $clog2(RETRY_PULSE) : 1;
    localparam int RCW = $clog2(MAX_RETRIES+1);

    localparam logic [TW-1:0]  TIMER_LAST = TW'(CAL_TIMEOUT - 1);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(RELEASE_HOLD - 1);
    localparam logic [PW-1:0]  PULSE_LAST = PW'(RETRY_PULSE - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_CAL = 3'd1;
    localparam logic [2:0] ST_HOLD     = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_RETRY    = 3'd4;
    localparam logic [2:0] ST_FAIL     = 3'd5;

    logic            sync1_q, cal_s_q;
    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [PW-1:0]   pulse_q, pulse_d;
    logic [RCW-1:0]  retry_q, retry_d;
    logic            retry_ok_s;
    logic            req_q, req_d;
    logic            sys_resetn_q, calib_done_q, calib_fail_q;

    // Two-flop synchroniser for the asynchronous calibration flag
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            cal_s_q <= 1'b0;
        end else begin
            sync1_q <= init_calib_complete;
            cal_s_q <= sync1_q;
        end
    end

`ifdef MIG_CALIB_RETRY_EN
    assign retry_ok_s = (retry_q < RCW'(MAX_RETRIES));
`else
    assign retry_ok_s = 1'b0;
`endif

    // Next-state and counter logic; a low mig_resetn overrides everything but RETRY/FAIL
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        pulse_d = pulse_q;
        retry_d = retry_q;
        if (!mig_resetn && (state_q != ST_RETRY) && (state_q != ST_FAIL)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mig_resetn) begin
                        state_d = ST_WAIT_CAL;
                        timer_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_CAL: begin
                    if (cal_s_q) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else if (timer_q == TIMER_LAST) begin
                        if (retry_ok_s) begin
                            state_d = ST_RETRY;
                            pulse_d = '0;
                            retry_d = retry_q + RCW'(1);
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!cal_s_q) begin
                        state_d = ST_WAIT_CAL;
                        timer_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                ST_RUN: begin
                    if (!cal_s_q) begin
                        state_d = ST_WAIT_CAL;
                        timer_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RETRY: begin
                    if (pulse_q == PULSE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        pulse_d = pulse_q + PW'(1);
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Retry request is decoded from the next state so it rises on the RETRY entry edge
    always_comb begin
`ifdef MIG_CALIB_RETRY_EN
        req_d = (state_d == ST_RETRY);
`else
        req_d = 1'b0;
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            hold_q       <= '0;
            pulse_q      <= '0;
            retry_q      <= '0;
            req_q        <= 1'b0;
            sys_resetn_q <= 1'b0;
            calib_done_q <= 1'b0;
            calib_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            hold_q       <= hold_d;
            pulse_q      <= pulse_d;
            retry_q      <= retry_d;
            req_q        <= req_d;
            sys_resetn_q <= (state_d == ST_RUN);
            calib_done_q <= (state_d == ST_RUN);
            calib_fail_q <= (state_d == ST_FAIL);
        end
    end

    assign mig_reset_req = req_q;
    assign sys_resetn    = sys_resetn_q;
    assign calib_done    = calib_done_q;
    assign calib_fail    = calib_fail_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_mig_calib_monitor.sv
// Directed bench for mig_calib_monitor; retry scenarios run when MIG_CALIB_RETRY_EN is
// defined, the immediate-fail scenario otherwise.
module tb_mig_calib_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       mig_resetn;
    logic       init_calib_complete;
    logic       mig_reset_req;
    logic       sys_resetn;
    logic       calib_done;
    logic       calib_fail;
    logic [1:0] retry_count;

    int checks   = 0;
    int failures = 0;
    logic req_seen = 1'b0;

    mig_calib_monitor #(
        .CAL_TIMEOUT  (100),
        .RELEASE_HOLD (4),
        .MAX_RETRIES  (2),
        .RETRY_PULSE  (8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mig_resetn          (mig_resetn),
        .init_calib_complete (init_calib_complete),
        .mig_reset_req       (mig_reset_req),
        .sys_resetn          (sys_resetn),
        .calib_done          (calib_done),
        .calib_fail          (calib_fail),
        .retry_count         (retry_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mig_reset_req === 1'b1) req_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mig_resetn = 1'b0;
        init_calib_complete = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_sys_resetn", {31'd0, sys_resetn}, 32'd0);
        check_eq("rst_req", {31'd0, mig_reset_req}, 32'd0);
        check_eq("rst_done", {31'd0, calib_done}, 32'd0);
        check_eq("rst_fail", {31'd0, calib_fail}, 32'd0);
        check_eq("rst_retry", {30'd0, retry_count}, 32'd0);

        // Normal release: calibration 20 cycles after mig_resetn, release 7 cycles later
        mig_resetn = 1'b1;
        tick(20);
        init_calib_complete = 1'b1;
        tick(6);
        check_eq("t1_pre_release", {31'd0, sys_resetn}, 32'd0);
        tick(1);
        check_eq("t1_sys_resetn", {31'd0, sys_resetn}, 32'd1);
        check_eq("t1_done", {31'd0, calib_done}, 32'd1);
        check_eq("t1_retry", {30'd0, retry_count}, 32'd0);
        check_eq("t1_fail", {31'd0, calib_fail}, 32'd0);

        // Loss of calibration in RUN
        init_calib_complete = 1'b0;
        tick(2);
        check_eq("t5_loss_still_up", {31'd0, sys_resetn}, 32'd1);
        tick(1);
        check_eq("t5_loss_down", {31'd0, sys_resetn}, 32'd0);
        check_eq("t5_loss_done", {31'd0, calib_done}, 32'd0);
        init_calib_complete = 1'b1;
        tick(7);
        check_eq("t5_rerun", {31'd0, sys_resetn}, 32'd1);

        // mig_resetn drop in RUN: immediate, then IDLE->WAIT->HOLD->RUN takes 6 edges
        mig_resetn = 1'b0;
        tick(1);
        check_eq("t5_mig_down", {31'd0, sys_resetn}, 32'd0);
        check_eq("t5_mig_done", {31'd0, calib_done}, 32'd0);
        tick(2);
        mig_resetn = 1'b1;
        tick(5);
        check_eq("t5_idle_pre", {31'd0, sys_resetn}, 32'd0);
        tick(1);
        check_eq("t5_idle_release", {31'd0, sys_resetn}, 32'd1);

        // Glitch during HOLD
        do_reset();
        mig_resetn = 1'b1;
        tick(5);
        init_calib_complete = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("t2_glitch_hi", {31'd0, sys_resetn}, 32'd0);
        end
        init_calib_complete = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_eq("t2_glitch_lo", {31'd0, sys_resetn}, 32'd0);
        end
        init_calib_complete = 1'b1;
        tick(6);
        check_eq("t2_pre_release", {31'd0, sys_resetn}, 32'd0);
        tick(1);
        check_eq("t2_release", {31'd0, sys_resetn}, 32'd1);

`ifdef MIG_CALIB_RETRY_EN
        // Retries then success
        do_reset();
        mig_resetn = 1'b1;
        tick(1);
        tick(99);
        check_eq("t3_r1_pre_req", {31'd0, mig_reset_req}, 32'd0);
        check_eq("t3_r1_pre_cnt", {30'd0, retry_count}, 32'd0);
        tick(1);
        check_eq("t3_r1_req", {31'd0, mig_reset_req}, 32'd1);
        check_eq("t3_r1_cnt", {30'd0, retry_count}, 32'd1);
        tick(7);
        check_eq("t3_r1_req_end", {31'd0, mig_reset_req}, 32'd1);
        tick(1);
        check_eq("t3_r1_req_fall", {31'd0, mig_reset_req}, 32'd0);
        tick(100);
        check_eq("t3_r2_pre_req", {31'd0, mig_reset_req}, 32'd0);
        tick(1);
        check_eq("t3_r2_req", {31'd0, mig_reset_req}, 32'd1);
        check_eq("t3_r2_cnt", {30'd0, retry_count}, 32'd2);
        tick(8);
        check_eq("t3_r2_req_fall", {31'd0, mig_reset_req}, 32'd0);
        tick(11);
        init_calib_complete = 1'b1;
        tick(7);
        check_eq("t3_run", {31'd0, sys_resetn}, 32'd1);
        check_eq("t3_run_cnt", {30'd0, retry_count}, 32'd2);
        check_eq("t3_run_fail", {31'd0, calib_fail}, 32'd0);

        // Exhausted retries
        do_reset();
        mig_resetn = 1'b1;
        tick(1);
        tick(109);
        tick(109);
        tick(99);
        check_eq("t4_pre_fail", {31'd0, calib_fail}, 32'd0);
        tick(1);
        check_eq("t4_fail", {31'd0, calib_fail}, 32'd1);
        check_eq("t4_req", {31'd0, mig_reset_req}, 32'd0);
        check_eq("t4_cnt", {30'd0, retry_count}, 32'd2);
        mig_resetn = 1'b0;
        tick(3);
        init_calib_complete = 1'b1;
        mig_resetn = 1'b1;
        tick(20);
        check_eq("t4_sticky_fail", {31'd0, calib_fail}, 32'd1);
        check_eq("t4_sticky_sys", {31'd0, sys_resetn}, 32'd0);
        check_eq("t4_sticky_done", {31'd0, calib_done}, 32'd0);
        reset = 1'b1;
        tick(1);
        check_eq("t4_reset_clears", {31'd0, calib_fail}, 32'd0);
        reset = 1'b0;

        // Reset in the middle of a retry pulse
        do_reset();
        mig_resetn = 1'b1;
        tick(101);
        tick(3);
        check_eq("t7_mid_pulse", {31'd0, mig_reset_req}, 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("t7_req_cleared", {31'd0, mig_reset_req}, 32'd0);
        check_eq("t7_cnt_cleared", {30'd0, retry_count}, 32'd0);
        reset = 1'b0;
`else
        // No retry support: the first timeout fails directly
        do_reset();
        req_seen = 1'b0;
        mig_resetn = 1'b1;
        tick(1);
        tick(99);
        check_eq("t6_pre_fail", {31'd0, calib_fail}, 32'd0);
        tick(1);
        check_eq("t6_fail", {31'd0, calib_fail}, 32'd1);
        check_eq("t6_cnt", {30'd0, retry_count}, 32'd0);
        tick(20);
        check_eq("t6_sticky", {31'd0, calib_fail}, 32'd1);
        check_eq("t6_req_never", {31'd0, req_seen}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
